// File: rtl/sound_event_queue.sv
// Spaces game apple-eaten events into single eat pulses for the buzzer controller.
// A game-over event flushes the queue and raises game_over_o only after any beep in progress has finished.
module sound_event_queue #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned EAT_HOLDOFF = 5_035_000,
  parameter int unsigned GO_HOLDOFF  = 12_587_500,
  localparam int unsigned CW         = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          apple_eaten_i,
  input  logic          game_over_i,
  output logic          eat_trigger_o,
  output logic          game_over_o,
  output logic [CW-1:0] queue_count_o,
  output logic          overflow_o,
  output logic          busy_o
);

  localparam int unsigned TW     = 32;
  localparam logic [TW-1:0] EAT_T = TW'(EAT_HOLDOFF);
  localparam logic [TW-1:0] GO_T  = TW'(GO_HOLDOFF);
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_GO_PEND,
    S_OVER
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] count_d;
  logic          apple_last, go_last;
  logic          eat_d, go_d, ovf_d, busy_d;
  logic          ap_edge, go_edge;
  logic          push, pop, flush;
  logic [TW-1:0] timer_dec;

  assign ap_edge   = apple_eaten_i & ~apple_last;
  assign go_edge   = game_over_i & ~go_last;
  assign timer_dec = (timer_q == '0) ? '0 : timer_q - TW'(1);

  // State, timer, event counter and all registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_HOLD;
      timer_q       <= EAT_T;
      queue_count_o <= '0;
      eat_trigger_o <= 1'b0;
      game_over_o   <= 1'b0;
      overflow_o    <= 1'b0;
      busy_o        <= 1'b0;
      apple_last    <= 1'b0;
      go_last       <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      queue_count_o <= count_d;
      eat_trigger_o <= eat_d;
      game_over_o   <= go_d;
      overflow_o    <= ovf_d;
      busy_o        <= busy_d;
      apple_last    <= apple_eaten_i;
      go_last       <= game_over_i;
    end
  end

  // Next-state, timer and queue control
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    count_d = queue_count_o;
    eat_d   = 1'b0;
    go_d    = game_over_o;
    ovf_d   = overflow_o;
    pop     = 1'b0;
    flush   = 1'b0;
    push    = ap_edge & ((state_q == S_IDLE) | (state_q == S_HOLD));

    case (state_q)
      S_IDLE: begin
        if (go_edge) begin
          flush   = 1'b1;
          go_d    = 1'b1;
          timer_d = GO_T;
          state_d = S_OVER;
        end else if (queue_count_o != '0) begin
          pop     = 1'b1;
          eat_d   = 1'b1;
          timer_d = EAT_T;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        timer_d = timer_dec;
        if (go_edge) begin
          flush   = 1'b1;
          state_d = S_GO_PEND;
        end else if (timer_q <= TW'(1)) begin
          state_d = S_IDLE;
        end
      end
      S_GO_PEND: begin
        if (!game_over_i) begin
          timer_d = timer_dec;
          state_d = S_HOLD;
        end else if (timer_q == '0) begin
          go_d    = 1'b1;
          timer_d = GO_T;
          state_d = S_OVER;
        end else begin
          timer_d = timer_dec;
        end
      end
      S_OVER: begin
        timer_d = timer_dec;
        if (!game_over_i) begin
          go_d    = 1'b0;
          state_d = S_HOLD;
        end
      end
      default: state_d = S_HOLD;
    endcase

    // A flush discards everything, including an apple edge in the same cycle
    if (flush) begin
      count_d = '0;
    end else if (push && pop) begin
      count_d = queue_count_o;
    end else if (push) begin
      if (queue_count_o == FULL) ovf_d = 1'b1;
      else                       count_d = queue_count_o + CW'(1);
    end else if (pop) begin
      count_d = queue_count_o - CW'(1);
    end

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_sound_event_queue.sv
// Directed and randomized bench for sound_event_queue against a queue-based reference model.
module tb_sound_event_queue;

  localparam int unsigned DEPTH       = 4;
  localparam int unsigned EAT_HOLDOFF = 10;
  localparam int unsigned GO_HOLDOFF  = 30;
  localparam int unsigned CW          = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          apple_eaten_i;
  logic          game_over_i;
  logic          eat_trigger_o;
  logic          game_over_o;
  logic [CW-1:0] queue_count_o;
  logic          overflow_o;
  logic          busy_o;

  always #5 clk = ~clk;

  sound_event_queue #(
    .DEPTH(DEPTH),
    .EAT_HOLDOFF(EAT_HOLDOFF),
    .GO_HOLDOFF(GO_HOLDOFF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .apple_eaten_i(apple_eaten_i),
    .game_over_i(game_over_i),
    .eat_trigger_o(eat_trigger_o),
    .game_over_o(game_over_o),
    .queue_count_o(queue_count_o),
    .overflow_o(overflow_o),
    .busy_o(busy_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: pending events as a queue, silence as a countdown of remaining cycles
  typedef enum int {M_IDLE, M_HOLD, M_PEND, M_OVER} mode_t;
  mode_t mode;
  int    quiet;
  int    fifo[$];
  bit    m_eat, m_go, m_ovf, m_busy;
  bit    prev_ap, prev_go;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic enqueue();
    if (fifo.size() < DEPTH) fifo.push_back(cyc);
    else m_ovf = 1'b1;
  endtask

  task automatic model_step();
    bit rise_ap, rise_go;
    int dec;
    if (!rst_n) begin
      mode = M_HOLD; quiet = EAT_HOLDOFF; fifo.delete();
      m_eat = 0; m_go = 0; m_ovf = 0; m_busy = 0; prev_ap = 0; prev_go = 0;
      return;
    end
    rise_ap = apple_eaten_i && !prev_ap;
    rise_go = game_over_i && !prev_go;
    prev_ap = apple_eaten_i;
    prev_go = game_over_i;
    m_eat = 0;
    dec = (quiet > 0) ? quiet - 1 : 0;
    case (mode)
      M_IDLE: begin
        if (rise_go) begin
          fifo.delete(); m_go = 1; quiet = GO_HOLDOFF; mode = M_OVER;
        end else begin
          if (fifo.size() > 0) begin
            void'(fifo.pop_front()); m_eat = 1; quiet = EAT_HOLDOFF; mode = M_HOLD;
          end
          if (rise_ap) enqueue();
        end
      end
      M_HOLD: begin
        if (rise_go) begin
          fifo.delete(); mode = M_PEND;
        end else begin
          if (rise_ap) enqueue();
          if (quiet <= 1) mode = M_IDLE;
        end
        quiet = dec;
      end
      M_PEND: begin
        if (!game_over_i) begin
          mode = M_HOLD; quiet = dec;
        end else if (quiet == 0) begin
          m_go = 1; quiet = GO_HOLDOFF; mode = M_OVER;
        end else begin
          quiet = dec;
        end
      end
      default: begin
        quiet = dec;
        if (!game_over_i) begin
          m_go = 0; mode = M_HOLD;
        end
      end
    endcase
    m_busy = (mode != M_IDLE);
  endtask

  // One clock: advance model at the edge, compare all outputs 1 time unit later
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    check("eat_trigger", 32'(eat_trigger_o), 32'(m_eat));
    check("game_over",   32'(game_over_o),   32'(m_go));
    check("queue_count", 32'(queue_count_o), 32'(fifo.size()));
    check("overflow",    32'(overflow_o),    32'(m_ovf));
    check("busy",        32'(busy_o),        32'(m_busy));
  endtask

  initial begin
    int first, pulses, busy_run, peak, g, fall, hi, p, rise;
    int pc[$];
    bit go_seen;

    rst_n = 1'b0; apple_eaten_i = 1'b0; game_over_i = 1'b0;
    repeat (3) tick();
    check("reset_busy", 32'(busy_o), 32'(0));
    check("reset_count", 32'(queue_count_o), 32'(0));
    rst_n = 1'b1;
    cyc = 0;

    // Startup holdoff: apple at cycle 2, pulse only after the holdoff
    tick();
    apple_eaten_i = 1'b1; tick(); apple_eaten_i = 1'b0;
    first = -1; pulses = 0; busy_run = 0;
    while (cyc < 25) begin
      tick();
      if (eat_trigger_o) begin
        pulses++;
        if (first < 0) first = cyc;
      end
      if (first >= 0 && cyc >= first && cyc < first + 11 && busy_o) busy_run++;
    end
    check("t1_pulses", 32'(pulses), 32'(1));
    check("t1_first_window", 32'(first >= 11 && first <= 12), 32'(1));
    check("t1_busy_run", 32'(busy_run), 32'(10));

    // Burst of 6 edges into a 4-deep queue while holding
    pc.delete(); peak = 0;
    apple_eaten_i = 1'b1; tick(); apple_eaten_i = 1'b0; tick();
    check("t2_first_pulse", 32'(eat_trigger_o), 32'(1));
    pc.push_back(cyc);
    for (int k = 0; k < 6; k++) begin
      apple_eaten_i = 1'b1; tick();
      if (eat_trigger_o) pc.push_back(cyc);
      if (int'(queue_count_o) > peak) peak = int'(queue_count_o);
      if (k == 5) begin
        check("t3_full_pop_count", 32'(queue_count_o), 32'(4));
        check("t3_full_pop_ovf", 32'(overflow_o), 32'(1));
      end
      apple_eaten_i = 1'b0; tick();
      if (eat_trigger_o) pc.push_back(cyc);
      if (int'(queue_count_o) > peak) peak = int'(queue_count_o);
    end
    repeat (60) begin
      tick();
      if (eat_trigger_o) pc.push_back(cyc);
    end
    check("t2_peak", 32'(peak), 32'(4));
    check("t2_overflow", 32'(overflow_o), 32'(1));
    check("t2_pulse_total", 32'(pc.size()), 32'(6));
    for (int i = 1; i < pc.size(); i++)
      check("t2_spacing", 32'(pc[i] - pc[i-1]), 32'(EAT_HOLDOFF + 1));
    check("t2_final_count", 32'(queue_count_o), 32'(0));

    // Game over during hold with 3 queued: flush, wait for the timer, then raise
    apple_eaten_i = 1'b1; tick(); apple_eaten_i = 1'b0; tick();
    p = cyc;
    for (int k = 0; k < 3; k++) begin
      apple_eaten_i = 1'b1; tick(); apple_eaten_i = 1'b0;
      if (k < 2) tick();
    end
    check("t4_queued", 32'(queue_count_o), 32'(3));
    game_over_i = 1'b1; tick(); g = cyc;
    check("t4_flushed", 32'(queue_count_o), 32'(0));
    rise = -1;
    for (int i = 0; i < 20 && rise < 0; i++) begin
      apple_eaten_i = ~apple_eaten_i; tick();
      if (game_over_o) rise = cyc;
    end
    check("t4_rise_delay", 32'(rise - g), 32'(5));
    check("t4_rise_vs_pulse", 32'(rise - p), 32'(EAT_HOLDOFF + 1));
    repeat (6) begin apple_eaten_i = ~apple_eaten_i; tick(); end
    check("t4_drop_count", 32'(queue_count_o), 32'(0));
    check("t4_go_held", 32'(game_over_o), 32'(1));
    apple_eaten_i = 1'b0; game_over_i = 1'b0; tick();
    check("t4_go_drop", 32'(game_over_o), 32'(0));
    fall = -1;
    for (int i = 0; i < 60 && fall < 0; i++) begin
      tick();
      if (!busy_o) fall = cyc;
    end
    check("t4_idle_reached", 32'(fall > 0), 32'(1));

    // Game over from idle, released after 5 cycles
    game_over_i = 1'b1; tick(); g = cyc; hi = 0;
    if (game_over_o) hi++;
    repeat (4) begin tick(); if (game_over_o) hi++; end
    game_over_i = 1'b0; tick();
    if (game_over_o) hi++;
    check("t5_go_cycles", 32'(hi), 32'(5));
    fall = -1;
    for (int i = 0; i < 40 && fall < 0; i++) begin
      tick();
      if (!busy_o) fall = cyc;
    end
    check("t5_busy_len", 32'(fall - g), 32'(GO_HOLDOFF));
    apple_eaten_i = 1'b1; tick(); apple_eaten_i = 1'b0; tick();
    check("t5_after_pulse", 32'(eat_trigger_o), 32'(1));

    // Short game-over blip during hold is cancelled
    repeat (12) tick();
    apple_eaten_i = 1'b1; tick(); apple_eaten_i = 1'b0; tick();
    p = cyc;
    repeat (2) tick();
    game_over_i = 1'b1; go_seen = 0;
    repeat (2) begin tick(); if (game_over_o) go_seen = 1; end
    game_over_i = 1'b0; fall = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (game_over_o) go_seen = 1;
      if (!busy_o && fall < 0) fall = cyc;
    end
    check("t6_go_never", 32'(go_seen), 32'(0));
    check("t6_idle_at", 32'(fall - p), 32'(EAT_HOLDOFF));

    // Randomized traffic with one mid-run reset
    for (int i = 0; i < 3000; i++) begin
      apple_eaten_i = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 3) game_over_i = ~game_over_i;
      rst_n = !(i >= 1500 && i < 1502);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
